// File: rtl/pal_cfg_pkg.sv
// Shared constants, chain-length helpers and FSM states for the PAL config loader.
package pal_cfg_pkg;

    localparam int PAL_N = 8;
    localparam int PAL_M = 6;
    localparam int PAL_P = 15;

    // Chain length: AND plane (2 literals per input per product term) plus OR plane.
    function automatic int cfg_bits_f(input int n, input int m, input int p);
        return 2 * n * p + p * m;
    endfunction

    function automatic int cfg_bytes_f(input int bits);
        return (bits + 7) / 8;
    endfunction

    localparam int CFG_BITS_DEF  = cfg_bits_f(PAL_N, PAL_M, PAL_P);
    localparam int CFG_BYTES_DEF = cfg_bytes_f(CFG_BITS_DEF);
    localparam int BIT_CNT_W_DEF = $clog2(CFG_BITS_DEF + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DONE
    } state_e;

endpackage

// File: rtl/pal_cfg_loader_serializer.sv
// Byte-to-bit serializer: shift register plus one-byte hold buffer so a
// back-to-back byte source yields a gap-free LSB-first bit stream.
module pal_cfg_serializer (
    input  logic       clk,
    input  logic       res_n,
    input  logic       clr_i,
    input  logic       en_i,
    input  logic [7:0] data_i,
    input  logic       valid_i,
    output logic       emit_vld_o,
    output logic       emit_bit_o,
    output logic       h_full_nxt_o
);

    logic [7:0] sr_q, sr_d;
    logic [7:0] h_q, h_d;
    logic [3:0] rem_q, rem_d;
    logic       h_full_q, h_full_d;
    logic       direct;

    // Pick the source of this cycle's bit (SR, then hold, then incoming byte) and park any unused byte.
    always_comb begin
        sr_d       = sr_q;
        h_d        = h_q;
        rem_d      = rem_q;
        h_full_d   = h_full_q;
        emit_vld_o = 1'b0;
        emit_bit_o = 1'b0;
        direct     = en_i && (rem_q == 4'd0) && !h_full_q && valid_i;
        if (en_i) begin
            if (rem_q != 4'd0) begin
                emit_vld_o = 1'b1;
                emit_bit_o = sr_q[0];
                sr_d       = {1'b0, sr_q[7:1]};
                rem_d      = rem_q - 4'd1;
            end else if (h_full_q) begin
                emit_vld_o = 1'b1;
                emit_bit_o = h_q[0];
                sr_d       = {1'b0, h_q[7:1]};
                rem_d      = 4'd7;
                h_full_d   = 1'b0;
            end else if (valid_i) begin
                emit_vld_o = 1'b1;
                emit_bit_o = data_i[0];
                sr_d       = {1'b0, data_i[7:1]};
                rem_d      = 4'd7;
            end
        end
        // Byte not consumed directly: into SR if it will be empty, else into hold.
        if (valid_i && !direct) begin
            if ((rem_d == 4'd0) && !h_full_d) begin
                sr_d  = data_i;
                rem_d = 4'd8;
            end else begin
                h_d      = data_i;
                h_full_d = 1'b1;
            end
        end
        if (clr_i) begin
            sr_d     = 8'd0;
            h_d      = 8'd0;
            rem_d    = 4'd0;
            h_full_d = 1'b0;
        end
    end

    assign h_full_nxt_o = h_full_d;

    // Buffer state registers.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            sr_q     <= 8'd0;
            h_q      <= 8'd0;
            rem_q    <= 4'd0;
            h_full_q <= 1'b0;
        end else begin
            sr_q     <= sr_d;
            h_q      <= h_d;
            rem_q    <= rem_d;
            h_full_q <= h_full_d;
        end
    end

endmodule

// File: rtl/pal_cfg_loader.sv
// PAL configuration loader: byte valid/ready in, serial cfg bit + enable out,
// counts exactly CFG_BITS bits then reports done. All outputs registered.
module pal_cfg_loader
    import pal_cfg_pkg::*;
#(
    parameter int N        = PAL_N,
    parameter int M        = PAL_M,
    parameter int P        = PAL_P,
    parameter int CFG_BITS = cfg_bits_f(N, M, P)
) (
    input  logic                            clk,
    input  logic                            res_n,
    input  logic                            start,
    input  logic [7:0]                      s_data,
    input  logic                            s_valid,
    output logic                            s_ready,
    output logic                            cfg_bit,
    output logic                            cfg_en,
    output logic                            busy,
    output logic                            done,
    output logic [$clog2(CFG_BITS+1)-1:0]   bit_cnt
);

    localparam int BCW       = $clog2(CFG_BITS + 1);
    localparam int CFG_BYTES = cfg_bytes_f(CFG_BITS);
    localparam int BYW       = $clog2(CFG_BYTES + 1);
    localparam logic [BCW-1:0] BITS_LAST  = BCW'(CFG_BITS);
    localparam logic [BYW-1:0] BYTES_LAST = BYW'(CFG_BYTES);

    state_e         state_q;
    logic [BCW-1:0] bit_cnt_q, bit_cnt_d;
    logic [BYW-1:0] bytes_q, bytes_d;
    logic           s_ready_q, s_ready_d;
    logic           cfg_bit_q, cfg_en_q, busy_q, done_q;

    logic at_end, fire, ser_en, ser_clr;
    logic emit_vld, emit_bit, h_full_nxt;

    // start always wins over a same-cycle byte; serializer stops once the chain is full.
    assign at_end    = (bit_cnt_q == BITS_LAST);
    assign fire      = s_valid && s_ready_q && !start;
    assign ser_en    = (state_q == ST_LOAD) && !at_end && !start;
    assign ser_clr   = start || ((state_q == ST_LOAD) && at_end);
    assign bytes_d   = bytes_q + BYW'(fire);
    assign bit_cnt_d = bit_cnt_q + BCW'(emit_vld);
    assign s_ready_d = !h_full_nxt && (bytes_d != BYTES_LAST);

    pal_cfg_serializer u_ser (
        .clk          (clk),
        .res_n        (res_n),
        .clr_i        (ser_clr),
        .en_i         (ser_en),
        .data_i       (s_data),
        .valid_i      (fire),
        .emit_vld_o   (emit_vld),
        .emit_bit_o   (emit_bit),
        .h_full_nxt_o (h_full_nxt)
    );

    // Load FSM with byte/bit counters and registered outputs.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            bytes_q   <= '0;
            s_ready_q <= 1'b0;
            cfg_bit_q <= 1'b0;
            cfg_en_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else if (start) begin
            state_q   <= ST_LOAD;
            bit_cnt_q <= '0;
            bytes_q   <= '0;
            s_ready_q <= 1'b1;
            cfg_bit_q <= 1'b0;
            cfg_en_q  <= 1'b0;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    if (at_end) begin
                        state_q   <= ST_DONE;
                        s_ready_q <= 1'b0;
                        cfg_bit_q <= 1'b0;
                        cfg_en_q  <= 1'b0;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                    end else begin
                        bit_cnt_q <= bit_cnt_d;
                        bytes_q   <= bytes_d;
                        s_ready_q <= s_ready_d;
                        cfg_en_q  <= emit_vld;
                        cfg_bit_q <= emit_vld ? emit_bit : 1'b0;
                    end
                end
                default: begin
                    s_ready_q <= 1'b0;
                    cfg_bit_q <= 1'b0;
                    cfg_en_q  <= 1'b0;
                end
            endcase
        end
    end

    assign s_ready = s_ready_q;
    assign cfg_bit = cfg_bit_q;
    assign cfg_en  = cfg_en_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign bit_cnt = bit_cnt_q;

endmodule

// File: tb/tb_pal_cfg_loader.sv
// Bench for pal_cfg_loader: queue-based stream model checked every cycle on the
// default instance, plus directed checks incl. a 40-bit corner instance.
module tb_pal_cfg_loader;
    import pal_cfg_pkg::*;

    localparam int NB    = CFG_BYTES_DEF;
    localparam int NBITS = CFG_BITS_DEF;
    localparam int BCW   = BIT_CNT_W_DEF;

    logic clk = 1'b0;
    logic res_n = 1'b0;
    logic start = 1'b0, s_valid = 1'b0;
    logic [7:0] s_data = 8'h00;
    logic s_ready, cfg_bit, cfg_en, busy, done;
    logic [BCW-1:0] bit_cnt;

    logic c_start = 1'b0, c_s_valid = 1'b0;
    logic [7:0] c_s_data = 8'h00;
    logic c_s_ready, c_cfg_bit, c_cfg_en, c_busy, c_done;
    logic [5:0] c_bit_cnt;

    always #5 clk = ~clk;

    pal_cfg_loader dut (
        .clk(clk), .res_n(res_n), .start(start), .s_data(s_data), .s_valid(s_valid),
        .s_ready(s_ready), .cfg_bit(cfg_bit), .cfg_en(cfg_en), .busy(busy),
        .done(done), .bit_cnt(bit_cnt)
    );

    pal_cfg_loader #(.N(4), .M(2), .P(4)) dut_c (
        .clk(clk), .res_n(res_n), .start(c_start), .s_data(c_s_data), .s_valid(c_s_valid),
        .s_ready(c_s_ready), .cfg_bit(c_cfg_bit), .cfg_en(c_cfg_en), .busy(c_busy),
        .done(c_done), .bit_cnt(c_bit_cnt)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- stream model (default instance) ----------------
    logic [7:0] acc[$];
    logic       d_bits[$];
    int  cnt = 0, run = 0, max_run = 0, en_total = 0;
    bit  m_busy = 0, m_done = 0, p_start = 0, p_hs = 0;
    logic [7:0] p_byte, m_b;

    // Outputs observed at negedge reflect the handshake/start seen at the previous negedge.
    always @(negedge clk) begin
        if (!res_n) begin
            acc.delete();
            cnt = 0; run = 0;
            m_busy = 0; m_done = 0; p_start = 0; p_hs = 0;
        end else begin
            if (p_start) begin
                acc.delete(); d_bits.delete();
                cnt = 0; run = 0; max_run = 0; en_total = 0;
                m_busy = 1; m_done = 0;
            end else if (p_hs) begin
                acc.push_back(p_byte);
                chk("bytes accepted <= CFG_BYTES", acc.size() <= NB, 1);
            end
            chk("done", done, m_done);
            chk("busy", busy, m_busy);
            if (!m_busy) chk("s_ready outside load", s_ready, 0);
            else if (s_ready) chk("s_ready with bytes outstanding", acc.size() < NB, 1);
            if (cfg_en) begin
                chk("cfg_en legal", m_busy && (cnt < NBITS) && ((cnt / 8) < acc.size()), 1);
                if ((cnt / 8) < acc.size()) begin
                    m_b = acc[cnt / 8];
                    chk("cfg_bit", cfg_bit, m_b[cnt % 8]);
                end
                d_bits.push_back(cfg_bit);
                cnt++; run++; en_total++;
                if (run > max_run) max_run = run;
            end else begin
                run = 0;
            end
            chk("bit_cnt", bit_cnt, cnt);
            if (m_busy && cnt == NBITS) begin
                m_busy = 0;
                m_done = 1;
            end
            p_start = start;
            p_hs    = s_valid && s_ready && !start;
            p_byte  = s_data;
        end
    end

    // Corner instance observation.
    logic c_bits[$];
    int   c_acc = 0;
    always @(negedge clk) begin
        if (res_n) begin
            if (c_cfg_en) c_bits.push_back(c_cfg_bit);
            if (c_s_valid && c_s_ready && !c_start) c_acc++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse_start(input bit with_byte);
        start = 1'b1;
        if (with_byte) begin
            s_valid = 1'b1;
            s_data  = 8'hEE;
        end
        step();
        start   = 1'b0;
        s_valid = 1'b0;
    endtask

    task automatic send_bytes(input int n, input int gap, input int abort_at, output bit aborted);
        bit got;
        int t;
        aborted = 0;
        for (int i = 0; i < n; i++) begin
            if (gap > 0) begin
                s_valid = 1'b0;
                repeat (gap) step();
            end
            s_valid = 1'b1;
            s_data  = 8'(i);
            got = 0;
            t   = 0;
            while (!got) begin
                got = s_ready;
                step();
                if (abort_at > 0 && int'(bit_cnt) >= abort_at) begin
                    aborted = 1;
                    return;
                end
                if (!got) begin
                    t++;
                    if (t > 500) begin
                        chk("handshake timeout", 0, 1);
                        s_valid = 1'b0;
                        return;
                    end
                end
            end
        end
        s_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int t;
        t = 0;
        while (!done && t < budget) begin
            step();
            t++;
        end
        chk("done reached within budget", done, 1);
    endtask

    logic ref_bits[$];
    logic [7:0] cb[5];

    initial begin
        bit ab;
        int mis;
        cb[0] = 8'h81; cb[1] = 8'h42; cb[2] = 8'h24; cb[3] = 8'h18; cb[4] = 8'hFF;

        // Reset state
        res_n = 1'b0;
        repeat (2) step();
        chk("rst s_ready", s_ready, 0);
        chk("rst cfg_en", cfg_en, 0);
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst bit_cnt", bit_cnt, 0);
        res_n = 1'b1;
        step();

        // Idle ignores bytes
        s_valid = 1'b1; s_data = 8'hFF;
        repeat (4) begin
            step();
            chk("idle s_ready", s_ready, 0);
            chk("idle cfg_en", cfg_en, 0);
            chk("idle done", done, 0);
        end
        s_valid = 1'b0;

        // Async reset in the middle of a load
        pulse_start(0);
        s_valid = 1'b1; s_data = 8'h5A;
        repeat (6) step();
        s_valid = 1'b0;
        chk("busy before reset", busy, 1);
        @(posedge clk);
        #3 res_n = 1'b0;
        #1;
        chk("async rst cfg_en", cfg_en, 0);
        chk("async rst cfg_bit", cfg_bit, 0);
        chk("async rst s_ready", s_ready, 0);
        chk("async rst busy", busy, 0);
        chk("async rst bit_cnt", bit_cnt, 0);
        chk("async rst corner busy/en", {c_busy, c_cfg_en, c_done, c_s_ready}, 0);
        step(); step();
        res_n = 1'b1;
        step();

        // Back-to-back stream, byte i = i
        pulse_start(0);
        chk("s_ready after start", s_ready, 1);
        chk("busy after start", busy, 1);
        send_bytes(NB, 0, 0, ab);
        chk("s_ready after last byte", s_ready, 0);
        wait_done(400);
        step();
        chk("stream cfg_en cycles", en_total, NBITS);
        chk("stream contiguous run", max_run, NBITS);
        chk("stream bit_cnt final", bit_cnt, NBITS);
        chk("stream bits captured", d_bits.size(), NBITS);
        chk("stream bit0 (byte0)", d_bits[0], 0);
        chk("stream bit8 (byte1 b0)", d_bits[8], 1);
        chk("stream bit17 (byte2 b1)", d_bits[17], 1);
        chk("stream bit323 (byte40 b3)", d_bits[323], 1);
        chk("stream bit328 (byte41 b0)", d_bits[328], 1);
        chk("stream bit329 (byte41 b1)", d_bits[329], 0);
        ref_bits = d_bits;

        // Bytes offered in DONE are refused
        s_valid = 1'b1; s_data = 8'hFF;
        repeat (4) begin
            step();
            chk("done s_ready", s_ready, 0);
            chk("done cfg_en", cfg_en, 0);
            chk("done held", done, 1);
            chk("done bit_cnt held", bit_cnt, NBITS);
        end
        s_valid = 1'b0;

        // Gappy source: one byte offered every 11th cycle
        pulse_start(0);
        send_bytes(NB, 10, 0, ab);
        wait_done(800);
        step();
        chk("gappy cfg_en cycles", en_total, NBITS);
        chk("gappy has bubbles", max_run < NBITS, 1);
        chk("gappy bit_cnt final", bit_cnt, NBITS);
        mis = 0;
        if (d_bits.size() != ref_bits.size()) mis = -1;
        else foreach (ref_bits[j]) if (d_bits[j] !== ref_bits[j]) mis++;
        chk("gappy stream equals back-to-back stream", mis, 0);

        // Abort after 100 bits, start coinciding with a valid byte
        pulse_start(0);
        send_bytes(NB, 0, 100, ab);
        chk("abort point reached", ab, 1);
        pulse_start(1);
        chk("abort bit_cnt cleared", bit_cnt, 0);
        chk("abort done low", done, 0);
        chk("abort busy", busy, 1);
        send_bytes(NB, 0, 0, ab);
        wait_done(400);
        step();
        chk("reload cfg_en cycles", en_total, NBITS);
        mis = 0;
        if (d_bits.size() != ref_bits.size()) mis = -1;
        else foreach (ref_bits[j]) if (d_bits[j] !== ref_bits[j]) mis++;
        chk("reload stream equals reference", mis, 0);

        // Corner instance: 40-bit chain, final byte used in full
        c_bits.delete();
        c_acc = 0;
        c_start = 1'b1;
        step();
        c_start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            bit got;
            int t;
            c_s_valid = 1'b1;
            c_s_data  = cb[k];
            got = 0;
            t   = 0;
            while (!got && t < 50) begin
                got = c_s_ready;
                step();
                t++;
            end
            chk("corner byte accepted", got, 1);
        end
        c_s_data = 8'h77;
        repeat (60) step();
        chk("corner s_ready after 5 bytes", c_s_ready, 0);
        c_s_valid = 1'b0;
        chk("corner bytes accepted", c_acc, 5);
        chk("corner cfg_en cycles", c_bits.size(), 40);
        chk("corner done", c_done, 1);
        chk("corner bit_cnt", c_bit_cnt, 40);
        chk("corner bit0", c_bits[0], 1);
        chk("corner bit1", c_bits[1], 0);
        chk("corner bit32 (last byte b0)", c_bits[32], 1);
        chk("corner bit39 (last byte b7)", c_bits[39], 1);
        if (c_bits.size() == 40) begin
            for (int j = 0; j < 40; j++) begin
                logic [7:0] b;
                b = cb[j / 8];
                chk("corner stream bit", c_bits[j], b[j % 8]);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/pal_cfg_loader.md
Name: pal_cfg_loader

Overview:
Upstream configuration feeder for the PAL fabric. It accepts configuration bytes over a valid/ready byte interface and serialises them LSB-first into the PAL's single-bit cfg input, asserting the PAL enable while the bits shift. It counts exactly CFG_BITS bits, discards any padding in the final byte, then reports done. A one-byte holding buffer keeps the bit stream gap-free when the source streams bytes back-to-back.

Parameters:
N, 8, PAL input count
M, 6, PAL output count
P, 15, PAL intermediate stage (product term) count
CFG_BITS, 2*N*P + P*M (330 at defaults), total configuration chain length in bits

Ports:
clk  in  1  clock; same clock as PAL.clk
res_n  in  1  asynchronous active-low reset
start  in  1  single-cycle pulse; begins or restarts a load
s_data  in  8  configuration byte, bit 0 shifted first
s_valid  in  1  s_data valid
s_ready  out  1  loader can take a byte this cycle
cfg_bit  out  1  serial configuration bit to PAL cfg
cfg_en  out  1  PAL enable; high exactly on cycles carrying a valid cfg_bit
busy  out  1  high in LOAD state
done  out  1  high from load completion until next start
bit_cnt  out  $clog2(CFG_BITS+1)  bits shifted so far in current load

Behaviour:
- Reset (async, res_n low): state IDLE; shift reg, hold reg, counters cleared; cfg_bit=0, cfg_en=0, s_ready=0, busy=0, done=0, bit_cnt=0. All outputs registered.
- States:
  - IDLE: s_ready=0. start -> LOAD.
  - LOAD: accepts bytes and shifts bits. After CFG_BITS bits -> DONE.
  - DONE: done=1, s_ready=0. start -> LOAD.
- start in any state: clears shift reg, hold reg and bit_cnt, drops done, enters LOAD next cycle. start mid-load aborts; the partial chain is left as-is in the PAL and is overwritten by the new load.
- Buffering:
  - Shift reg SR: 8 bits, remaining-bit count 0..8.
  - Hold reg H: 1 byte, full flag.
  - In LOAD: s_ready = !H.full && bytes_accepted < ceil(CFG_BITS/8).
  - Handshake fires on s_valid && s_ready. The byte goes to H, or directly to SR if SR is empty or emptying this cycle and H is empty.
- Shifting: each LOAD cycle with SR non-empty drives cfg_bit=SR[0], cfg_en=1, shifts SR right, and increments bit_cnt. SR empty means cfg_en=0 (bubble); the PAL ignores cfg while en is low.
- Latency: byte accepted at cycle k (SR empty) drives bit0 at cycle k+1 and bit7 at k+8.
- Throughput: with s_valid held high, bits are continuous, 1 bit/clk, no bubbles. The next byte moves H -> SR in the same cycle bit7 leaves.
- Final byte: only CFG_BITS mod 8 low bits are shifted (2 at defaults); upper bits are discarded. If CFG_BITS mod 8 = 0, the final byte is used in full.
- The cycle after bit_cnt reaches CFG_BITS: cfg_en=0, busy=0, done=1, state DONE. No further byte is accepted; bit_cnt holds CFG_BITS.
- s_valid while not ready: ignored, no side effects. The source must hold s_data stable until accepted.
- Simultaneous start and s_valid: start wins and the byte is not accepted in that cycle.

Decomposition:
- Package pal_cfg_pkg: N/M/P defaults, the CFG_BITS function 2*N*P+P*M, CFG_BYTES = ceil(CFG_BITS/8), the state enum {IDLE, LOAD, DONE}, and the bit_cnt width constant.
- One natural sub-module, pal_cfg_serializer: SR plus hold register plus remaining-bit count, with a byte valid/ready input and a bit/en output. The top level holds the FSM and the byte/bit counters.

Test Plan:
- Reset then idle: res_n low mid-cycle -> all outputs 0 immediately; s_ready=0 until start.
- Back-to-back stream, defaults: start, then 42 bytes with s_valid held high, pattern byte i = i -> cfg_en high for exactly 330 consecutive cycles. Serial stream equals bytes 0..40 LSB-first plus byte41 bits[1:0]. done=1 the cycle after bit 330. s_ready=0 after the 42nd byte.
- Gappy source: s_valid high only every 11th cycle -> cfg_en shows bubbles, the bit sequence is identical to the stream test, and bit_cnt ends at 330.
- Abort: start again after 100 bits -> next cycle bit_cnt=0 and done=0. A full 42-byte load then completes with exactly 330 further cfg_en cycles.
- Backpressure / overflow: in DONE, s_valid=1 with s_data=0xFF -> s_ready=0, no cfg_en, done stays 1. In IDLE, same behaviour.
- Corner parameter: N=4, M=2, P=4 (CFG_BITS=40) -> exactly 5 bytes accepted, all 8 bits of the final byte shifted, done after 40 cfg_en cycles.
